ahb_slave_if_p: RTL

Parametrised AHB-Lite slave front end for the AHB-to-APB bridge: it decodes a configurable number of equal-size APB regions, accepts address phases, and pipelines address, write data and direction for the bridge FSM. It drives HREADYOUT wait states until the bridge signals completion. It generates the two-cycle AHB ERROR response for unmapped or oversized transfers and for bridge timeouts. It sits between the AHB interconnect and the APB controller FSM.

---
 rtl/ahb_apb_pkg.sv | 31 +++
 rtl/ahb_region_decode.sv | 42 ++++
 rtl/ahb_slave_if_p.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings, FSM state type and defaults for the AHB-to-APB bridge.
package ahb_apb_pkg;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB responses
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Default memory map
    localparam logic [31:0] BASE_ADDR_DFLT   = 32'h8000_0000;
    localparam logic [31:0] REGION_SIZE_DFLT = 32'h0400_0000;

    // Slave front-end FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } slv_state_e;

    // True when a transfer of 8*2^hsize bits fits on a data bus of data_w bits.
    function automatic logic size_fits(input logic [2:0] hsize, input logic [31:0] data_w);
        return ((32'd8 << hsize) <= data_w);
    endfunction

endpackage

// File: rtl/ahb_region_decode.sv
// Decodes an AHB address into NUM_SLAVES equal, contiguous APB regions.
module ahb_region_decode
    import ahb_apb_pkg::*;
#(
    parameter int                NUM_SLAVES  = 3,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(BASE_ADDR_DFLT),
    parameter logic [ADDR_W-1:0] REGION_SIZE = ADDR_W'(REGION_SIZE_DFLT)
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output logic                  hit_o,
    output logic [NUM_SLAVES-1:0] sel_o
);

    // Widened arithmetic so the upper bound of the map can never wrap.
    localparam int               EXT_W   = ADDR_W + 32;
    localparam int               SHIFT   = $clog2(REGION_SIZE);
    localparam logic [EXT_W-1:0] BASE_X  = EXT_W'(BASE_ADDR);
    localparam logic [EXT_W-1:0] LIMIT_X = BASE_X + (EXT_W'(NUM_SLAVES) * EXT_W'(REGION_SIZE));

    logic [EXT_W-1:0] addr_x_s;
    logic [EXT_W-1:0] offset_x_s;
    logic [EXT_W-1:0] index_x_s;

    assign addr_x_s   = EXT_W'(addr_i);
    assign offset_x_s = addr_x_s - BASE_X;
    assign index_x_s  = offset_x_s >> SHIFT;
    assign hit_o      = (addr_x_s >= BASE_X) && (addr_x_s < LIMIT_X);

    // One-hot region select; all zero on a miss.
    always_comb begin
        sel_o = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hit_o && (index_x_s == EXT_W'(i))) begin
                sel_o[i] = 1'b1;
            end else begin
                sel_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_if_p.sv
// AHB-Lite slave front end: region decode, address/data pipeline, wait
// states while the APB side is busy, and the two-cycle ERROR response.
module ahb_slave_if_p
    import ahb_apb_pkg::*;
#(
    parameter int                NUM_SLAVES  = 3,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(BASE_ADDR_DFLT),
    parameter logic [ADDR_W-1:0] REGION_SIZE = ADDR_W'(REGION_SIZE_DFLT),
    parameter int                TIMEOUT     = 16
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  Hwrite,
    input  logic                  Hreadyin,
    input  logic [1:0]            Htrans,
    input  logic [2:0]            Hsize,
    input  logic [ADDR_W-1:0]     Haddr,
    input  logic [DATA_W-1:0]     Hwdata,
    input  logic [DATA_W-1:0]     Prdata,
    input  logic                  xfer_done,
    output logic                  valid,
    output logic [ADDR_W-1:0]     Haddr1,
    output logic [ADDR_W-1:0]     Haddr2,
    output logic [DATA_W-1:0]     Hwdata1,
    output logic [DATA_W-1:0]     Hwdata2,
    output logic                  Hwritereg,
    output logic [NUM_SLAVES-1:0] tempselx,
    output logic [DATA_W-1:0]     Hrdata,
    output logic [1:0]            Hresp,
    output logic                  Hreadyout
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    slv_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      haddr1_q, haddr2_q;
    logic [DATA_W-1:0]      hwdata1_q, hwdata2_q;
    logic                   hwrite_q;
    logic                   wdata_phase_q;
    logic                   active_s, hit_s, valid_s, bad_s;
    logic [NUM_SLAVES-1:0]  sel_s;
    logic                   hready_s;
    logic [1:0]             hresp_s;

    ahb_region_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .REGION_SIZE (REGION_SIZE)
    ) u_decode (
        .addr_i (Haddr),
        .hit_o  (hit_s),
        .sel_o  (sel_s)
    );

    assign active_s = Hreadyin && ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ))
                      && (state_q == ST_IDLE);
    assign valid_s  = active_s && hit_s && size_fits(Hsize, 32'(DATA_W)) && !Hreset;
    assign bad_s    = active_s && !valid_s;

    assign valid     = valid_s;
    assign tempselx  = Hreset ? {NUM_SLAVES{1'b0}} : sel_s;
    assign Hrdata    = Prdata;
    assign Haddr1    = haddr1_q;
    assign Haddr2    = haddr2_q;
    assign Hwdata1   = hwdata1_q;
    assign Hwdata2   = hwdata2_q;
    assign Hwritereg = hwrite_q;
    assign Hreadyout = hready_s;
    assign Hresp     = hresp_s;

    // Next state, timeout counter and the HREADYOUT/HRESP response.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hready_s = 1'b1;
        hresp_s  = HRESP_OKAY;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (valid_s) begin
                    state_d = ST_BUSY;
                end else if (bad_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                hready_s = xfer_done;
                // Completion takes priority over a coincident timeout.
                if (xfer_done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR1: begin
                hready_s = 1'b0;
                hresp_s  = HRESP_ERROR;
                state_d  = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_s = HRESP_ERROR;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and timeout counter registers.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address/direction pipeline, advanced only by accepted transfers.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            haddr1_q      <= {ADDR_W{1'b0}};
            haddr2_q      <= {ADDR_W{1'b0}};
            hwrite_q      <= 1'b0;
            wdata_phase_q <= 1'b0;
        end else begin
            wdata_phase_q <= valid_s && Hwrite;
            if (valid_s) begin
                haddr1_q <= Haddr;
                haddr2_q <= haddr1_q;
                hwrite_q <= Hwrite;
            end else begin
                haddr1_q <= haddr1_q;
                haddr2_q <= haddr2_q;
                hwrite_q <= hwrite_q;
            end
        end
    end

    // Write-data pipeline, sampled in the data phase of an accepted write.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            hwdata1_q <= {DATA_W{1'b0}};
            hwdata2_q <= {DATA_W{1'b0}};
        end else if (wdata_phase_q) begin
            hwdata1_q <= Hwdata;
            hwdata2_q <= hwdata1_q;
        end else begin
            hwdata1_q <= hwdata1_q;
            hwdata2_q <= hwdata2_q;
        end
    end

endmodule
